// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pkg
//  Description : Shared encodings for the EX->MEM stage: ALU op codes,
//                branch types, HI/LO result select, exception codes and
//                trap FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pkg;

  // ALU operation codes; anything above ALU_OP_MAX is a reserved op.
  localparam logic [3:0] ALU_OP_AND  = 4'd0;
  localparam logic [3:0] ALU_OP_OR   = 4'd1;
  localparam logic [3:0] ALU_OP_XOR  = 4'd2;
  localparam logic [3:0] ALU_OP_MULT = 4'd3;
  localparam logic [3:0] ALU_OP_DIV  = 4'd4;
  localparam logic [3:0] ALU_OP_ADD  = 4'd5;
  localparam logic [3:0] ALU_OP_ADDU = 4'd6;
  localparam logic [3:0] ALU_OP_SUB  = 4'd7;
  localparam logic [3:0] ALU_OP_SUBU = 4'd8;
  localparam logic [3:0] ALU_OP_SLT  = 4'd9;
  localparam logic [3:0] ALU_OP_SLL  = 4'd10;
  localparam logic [3:0] ALU_OP_SRL  = 4'd11;
  localparam logic [3:0] ALU_OP_SRA  = 4'd12;
  localparam logic [3:0] ALU_OP_MAX  = 4'd12;

  // Branch type (2'b11 is reserved and behaves as BR_NONE)
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  // Result select (2'b11 falls back to the ALU result)
  localparam logic [1:0] HILO_ALU = 2'b00;
  localparam logic [1:0] HILO_HI  = 2'b01;
  localparam logic [1:0] HILO_LO  = 2'b10;

  // Exception codes
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OF   = 2'b01;
  localparam logic [1:0] EXC_RSV  = 2'b10;

  // Trap FSM states
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem_stage_hilo_regs.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_regs
//  Description : Architectural HI/LO register pair written by mult/div.
//  Ports       : clock, reset (sync, active-high), we (write both),
//                hi_in/lo_in (write data), hi/lo (current values)
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_regs #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] hi_in,
  input  logic [W-1:0] lo_in,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we) begin
      hi_q <= hi_in;
      lo_q <= lo_in;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule : hilo_regs
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX->MEM pipeline register behind the registered ALU. Latches
//                ALU results and sideband, owns HI/LO, selects mfhi/mflo,
//                resolves beq/bne and traps on overflow / reserved ops.
//  Ports       : clock/reset, stall/flush control, in_* ALU outputs and
//                sideband, exc_ack; out_* committed instruction, hi/lo,
//                br_taken/br_target pulse, exc_* trap report, retired count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int W     = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [W-1:0]     in_pc,
  input  logic [3:0]       in_alu_op,
  input  logic [W-1:0]     in_result,
  input  logic [W-1:0]     in_result2,
  input  logic             in_of,
  input  logic             in_equal,
  input  logic             in_trap_of,
  input  logic [1:0]       in_br_type,
  input  logic [W-1:0]     in_br_target,
  input  logic             in_hilo_write,
  input  logic [1:0]       in_hilo_sel,
  input  logic [RW-1:0]    in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic [W-1:0]     in_store_data,
  input  logic             exc_ack,
  output logic             out_valid,
  output logic [W-1:0]     out_pc,
  output logic [W-1:0]     out_result,
  output logic [RW-1:0]    out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic [W-1:0]     out_store_data,
  output logic [W-1:0]     hi,
  output logic [W-1:0]     lo,
  output logic             br_taken,
  output logic [W-1:0]     br_target,
  output logic             exc_valid,
  output logic [1:0]       exc_code,
  output logic [W-1:0]     exc_pc,
  output logic [CNT_W-1:0] retired
);

  state_e            state_q;
  logic              out_valid_q;
  logic [W-1:0]      out_pc_q;
  logic [W-1:0]      out_result_q;
  logic [RW-1:0]     out_rd_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [W-1:0]      store_data_q;
  logic              br_taken_q;
  logic [W-1:0]      br_target_q;
  logic [1:0]        exc_code_q;
  logic [W-1:0]      exc_pc_q;
  logic [CNT_W-1:0]  retired_q;

  logic              accept_d;
  logic              illegal_d;
  logic              trap_d;
  logic              commit_d;
  logic              br_hit_d;
  logic [W-1:0]      result_d;
  logic [1:0]        exc_code_d;

  // ---------------------------------------------------------------------------
  // Combinational accept / trap decode and result select
  // ---------------------------------------------------------------------------
  always_comb begin
    accept_d   = in_valid & ~flush & ~stall & (state_q == ST_RUN);
    illegal_d  = is_illegal_op(in_alu_op);
    trap_d     = accept_d & (illegal_d | (in_trap_of & in_of));
    commit_d   = accept_d & ~trap_d;
    // Reserved op outranks overflow when both are present.
    exc_code_d = illegal_d ? EXC_RSV : EXC_OF;

    br_hit_d = 1'b0;
    case (in_br_type)
      BR_BEQ:  br_hit_d = in_equal;
      BR_BNE:  br_hit_d = ~in_equal;
      default: br_hit_d = 1'b0;
    endcase

    // hi/lo here are the pre-write values, so a mult that also selects HI
    // returns the old HI, matching sequential mthi/mfhi semantics.
    case (in_hilo_sel)
      HILO_HI: result_d = hi;
      HILO_LO: result_d = lo;
      default: result_d = in_result;
    endcase
  end

  hilo_regs #(
    .W (W)
  ) u_hilo_regs (
    .clock (clock),
    .reset (reset),
    .we    (commit_d & in_hilo_write),
    .hi_in (in_result2),
    .lo_in (in_result),
    .hi    (hi),
    .lo    (lo)
  );

  // ---------------------------------------------------------------------------
  // Stage register and trap FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      store_data_q <= '0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
      exc_code_q   <= EXC_NONE;
      exc_pc_q     <= '0;
      retired_q    <= '0;
    end else begin
      // br_taken is a one-shot: anything other than a fresh taken branch clears it.
      br_taken_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            out_valid_q <= 1'b0;
          end else if (stall) begin
            // hold everything; only the branch pulse drops
          end else if (in_valid) begin
            if (trap_d) begin
              out_valid_q <= 1'b0;
              exc_pc_q    <= in_pc;
              exc_code_q  <= exc_code_d;
              state_q     <= ST_TRAP;
            end else begin
              out_valid_q  <= 1'b1;
              out_pc_q     <= in_pc;
              out_result_q <= result_d;
              out_rd_q     <= in_rd;
              reg_write_q  <= in_reg_write;
              mem_read_q   <= in_mem_read;
              mem_write_q  <= in_mem_write;
              store_data_q <= in_store_data;
              br_taken_q   <= br_hit_d;
              br_target_q  <= in_br_target;
              retired_q    <= retired_q + 1'b1;
            end
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        ST_TRAP: begin
          // Inputs, flush and stall are all ignored until the handler acks.
          out_valid_q <= 1'b0;
          if (exc_ack) begin
            state_q    <= ST_RUN;
            exc_code_q <= EXC_NONE;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_result     = out_result_q;
  assign out_rd         = out_rd_q;
  assign out_reg_write  = out_valid_q & reg_write_q;
  assign out_mem_read   = out_valid_q & mem_read_q;
  assign out_mem_write  = out_valid_q & mem_write_q;
  assign out_store_data = store_data_q;
  assign br_taken       = br_taken_q;
  assign br_target      = br_target_q;
  assign exc_valid      = (state_q == ST_TRAP);
  assign exc_code       = exc_code_q;
  assign exc_pc         = exc_pc_q;
  assign retired        = retired_q;

endmodule : ex_mem_stage
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Directed self-checking bench for ex_mem_stage. A 4-bit
//                retired counter keeps the wrap-around case short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  localparam int W     = 32;
  localparam int RW    = 5;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             stall, flush, in_valid;
  logic [W-1:0]     in_pc, in_result, in_result2, in_br_target, in_store_data;
  logic [3:0]       in_alu_op;
  logic             in_of, in_equal, in_trap_of, in_hilo_write;
  logic [1:0]       in_br_type, in_hilo_sel;
  logic [RW-1:0]    in_rd;
  logic             in_reg_write, in_mem_read, in_mem_write, exc_ack;
  logic             out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic [W-1:0]     out_pc, out_result, out_store_data, hi, lo, br_target, exc_pc;
  logic [RW-1:0]    out_rd;
  logic             br_taken, exc_valid;
  logic [1:0]       exc_code;
  logic [CNT_W-1:0] retired;

  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_ret;

  always #5 clock = ~clock;

  ex_mem_stage #(.W(W), .RW(RW), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_op(in_alu_op),
    .in_result(in_result), .in_result2(in_result2), .in_of(in_of),
    .in_equal(in_equal), .in_trap_of(in_trap_of), .in_br_type(in_br_type),
    .in_br_target(in_br_target), .in_hilo_write(in_hilo_write),
    .in_hilo_sel(in_hilo_sel), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_store_data(in_store_data), .exc_ack(exc_ack),
    .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .hi(hi), .lo(lo), .br_taken(br_taken), .br_target(br_target),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .retired(retired)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; in_valid = 0; in_pc = '0; in_alu_op = ALU_OP_AND;
    in_result = '0; in_result2 = '0; in_of = 0; in_equal = 0; in_trap_of = 0;
    in_br_type = BR_NONE; in_br_target = '0; in_hilo_write = 0;
    in_hilo_sel = HILO_ALU; in_rd = '0; in_reg_write = 0; in_mem_read = 0;
    in_mem_write = 0; in_store_data = '0; exc_ack = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%0h exp=0", out_result); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%0h/%0h exp=0/0", hi, lo); end
    checks++; if (retired !== 4'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    checks++; if (exc_valid !== 1'b0 || exc_code !== 2'b00) begin failures++; $display("FAIL reset_exc got=%0b/%0b exp=0/00", exc_valid, exc_code); end
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL reset_br_taken got=%0b exp=0", br_taken); end
    reset = 0;
    exp_ret = '0;
  endtask

  task automatic test_hilo();
    clear_inputs();
    in_valid = 1; in_alu_op = ALU_OP_MULT; in_result = 32'h1; in_result2 = 32'h2;
    in_hilo_write = 1; in_pc = 32'h10;
    tick(); exp_ret++;
    checks++; if (hi !== 32'h2 || lo !== 32'h1) begin failures++; $display("FAIL mult_hilo got=%0h/%0h exp=2/1", hi, lo); end
    checks++; if (out_valid !== 1'b1 || retired !== exp_ret) begin failures++; $display("FAIL mult_commit got=%0b/%0d exp=1/%0d", out_valid, retired, exp_ret); end

    clear_inputs();
    in_valid = 1; in_alu_op = ALU_OP_OR; in_result = 32'h55; in_hilo_sel = HILO_HI;
    in_reg_write = 1; in_rd = 5'd5; in_pc = 32'h14; in_mem_write = 1; in_store_data = 32'hDEAD;
    tick(); exp_ret++;
    checks++; if (out_result !== 32'h2) begin failures++; $display("FAIL mfhi_result got=%0h exp=2", out_result); end
    checks++; if (out_reg_write !== 1'b1 || out_rd !== 5'd5 || out_pc !== 32'h14) begin failures++; $display("FAIL mfhi_side got=%0b/%0d/%0h exp=1/5/14", out_reg_write, out_rd, out_pc); end
    checks++; if (out_mem_write !== 1'b1 || out_store_data !== 32'hDEAD) begin failures++; $display("FAIL store_side got=%0b/%0h exp=1/dead", out_mem_write, out_store_data); end

    in_hilo_sel = HILO_LO; in_mem_write = 0;
    tick(); exp_ret++;
    checks++; if (out_result !== 32'h1) begin failures++; $display("FAIL mflo_result got=%0h exp=1", out_result); end

    // mult selecting HI in the same cycle sees the old HI
    clear_inputs();
    in_valid = 1; in_alu_op = ALU_OP_MULT; in_result = 32'h7; in_result2 = 32'h8;
    in_hilo_write = 1; in_hilo_sel = HILO_HI;
    tick(); exp_ret++;
    checks++; if (out_result !== 32'h2) begin failures++; $display("FAIL hilo_prewrite got=%0h exp=2", out_result); end
    checks++; if (hi !== 32'h8 || lo !== 32'h7) begin failures++; $display("FAIL hilo_update got=%0h/%0h exp=8/7", hi, lo); end

    in_hilo_write = 0; in_hilo_sel = 2'b11; in_result = 32'h55; in_reg_write = 1;
    tick(); exp_ret++;
    checks++; if (out_result !== 32'h55) begin failures++; $display("FAIL sel11_alu got=%0h exp=55", out_result); end

    clear_inputs();
    tick();
    checks++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin failures++; $display("FAIL idle_bubble got=%0b/%0b exp=0/0", out_valid, out_reg_write); end
    checks++; if (retired !== exp_ret) begin failures++; $display("FAIL idle_retired got=%0d exp=%0d", retired, exp_ret); end
  endtask

  task automatic test_trap();
    clear_inputs();
    in_valid = 1; in_alu_op = ALU_OP_ADD; in_trap_of = 1; in_of = 1; in_pc = 32'h40; in_reg_write = 1;
    tick();
    checks++; if (exc_valid !== 1'b1 || exc_code !== EXC_OF) begin failures++; $display("FAIL trap_of_exc got=%0b/%0b exp=1/01", exc_valid, exc_code); end
    checks++; if (exc_pc !== 32'h40) begin failures++; $display("FAIL trap_of_pc got=%0h exp=40", exc_pc); end
    checks++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || retired !== exp_ret) begin failures++; $display("FAIL trap_of_nocommit got=%0b/%0b/%0d exp=0/0/%0d", out_valid, out_reg_write, retired, exp_ret); end

    clear_inputs();
    in_valid = 1; in_alu_op = ALU_OP_MULT; in_hilo_write = 1; in_result = 32'hAA; in_result2 = 32'hBB; in_pc = 32'h44;
    tick(); tick();
    checks++; if (hi !== 32'h8 || lo !== 32'h7) begin failures++; $display("FAIL trap_drop_hilo got=%0h/%0h exp=8/7", hi, lo); end
    checks++; if (out_valid !== 1'b0 || exc_valid !== 1'b1 || retired !== exp_ret) begin failures++; $display("FAIL trap_drop_state got=%0b/%0b/%0d exp=0/1/%0d", out_valid, exc_valid, retired, exp_ret); end

    clear_inputs();
    exc_ack = 1;
    tick();
    checks++; if (exc_valid !== 1'b0 || exc_code !== EXC_NONE) begin failures++; $display("FAIL trap_ack got=%0b/%0b exp=0/00", exc_valid, exc_code); end

    // addu overflow does not trap; exc_ack while running is ignored
    clear_inputs();
    exc_ack = 1; in_valid = 1; in_alu_op = ALU_OP_ADDU; in_of = 1; in_result = 32'h33; in_pc = 32'h48;
    tick(); exp_ret++;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h33 || exc_valid !== 1'b0) begin failures++; $display("FAIL addu_no_trap got=%0b/%0h/%0b exp=1/33/0", out_valid, out_result, exc_valid); end
  endtask

  task automatic test_branch();
    clear_inputs();
    in_valid = 1; in_br_type = BR_BEQ; in_equal = 1; in_br_target = 32'h100; in_pc = 32'h80;
    tick(); exp_ret++;
    checks++; if (br_taken !== 1'b1 || br_target !== 32'h100) begin failures++; $display("FAIL beq_taken got=%0b/%0h exp=1/100", br_taken, br_target); end
    clear_inputs();
    tick();
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL beq_pulse_width got=%0b exp=0", br_taken); end
    in_valid = 1; in_br_type = BR_BNE; in_equal = 1; in_br_target = 32'h200;
    tick(); exp_ret++;
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL bne_eq got=%0b exp=0", br_taken); end
    in_equal = 0; in_br_target = 32'h204;
    tick(); exp_ret++;
    checks++; if (br_taken !== 1'b1 || br_target !== 32'h204) begin failures++; $display("FAIL bne_ne got=%0b/%0h exp=1/204", br_taken, br_target); end
    in_br_type = 2'b11; in_equal = 1;
    tick(); exp_ret++;
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL br_rsv got=%0b exp=0", br_taken); end
    in_br_type = BR_BEQ; in_equal = 0;
    tick(); exp_ret++;
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL beq_ne got=%0b exp=0", br_taken); end
  endtask

  task automatic test_stall();
    clear_inputs();
    in_valid = 1; in_alu_op = ALU_OP_MULT; in_result = 32'h11; in_result2 = 32'h22; in_hilo_write = 1;
    in_reg_write = 1; in_rd = 5'd3; in_pc = 32'h200; in_br_type = BR_BEQ; in_equal = 1; in_br_target = 32'h300;
    tick(); exp_ret++;
    checks++; if (br_taken !== 1'b1 || hi !== 32'h22) begin failures++; $display("FAIL pre_stall got=%0b/%0h exp=1/22", br_taken, hi); end

    stall = 1; in_result = 32'h99; in_result2 = 32'h98; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (hi !== 32'h22 || lo !== 32'h11 || out_valid !== 1'b1 || out_pc !== 32'h200 ||
          br_taken !== 1'b0 || retired !== exp_ret)
      begin
        failures++;
        $display("FAIL stall_hold[%0d] got hi=%0h lo=%0h v=%0b pc=%0h br=%0b ret=%0d exp 22/11/1/200/0/%0d",
                 i, hi, lo, out_valid, out_pc, br_taken, retired, exp_ret);
      end
    end

    flush = 1;
    tick();
    checks++; if (out_valid !== 1'b0 || hi !== 32'h22 || retired !== exp_ret) begin failures++; $display("FAIL flush_stall got=%0b/%0h/%0d exp=0/22/%0d", out_valid, hi, retired, exp_ret); end
    stall = 0;
    tick();
    checks++; if (out_valid !== 1'b0 || hi !== 32'h22 || br_taken !== 1'b0) begin failures++; $display("FAIL flush_only got=%0b/%0h/%0b exp=0/22/0", out_valid, hi, br_taken); end
  endtask

  task automatic test_reserved();
    clear_inputs();
    in_valid = 1; in_alu_op = 4'b1110; in_trap_of = 1; in_of = 1; in_pc = 32'h44;
    tick();
    checks++; if (exc_code !== EXC_RSV || exc_pc !== 32'h44 || retired !== exp_ret) begin failures++; $display("FAIL rsv_wins got=%0b/%0h/%0d exp=10/44/%0d", exc_code, exc_pc, retired, exp_ret); end
    clear_inputs(); exc_ack = 1;
    tick();
    in_valid = 1; in_alu_op = 4'd13; in_pc = 32'h50; exc_ack = 0;
    tick();
    checks++; if (exc_valid !== 1'b1 || exc_code !== EXC_RSV || exc_pc !== 32'h50) begin failures++; $display("FAIL rsv_op13 got=%0b/%0b/%0h exp=1/10/50", exc_valid, exc_code, exc_pc); end
    clear_inputs(); exc_ack = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_wrap();
    clear_inputs();
    in_valid = 1; in_alu_op = ALU_OP_SLT;
    while (exp_ret != 4'hF) begin
      tick(); exp_ret++;
    end
    checks++; if (retired !== 4'hF) begin failures++; $display("FAIL retired_max got=%0d exp=15", retired); end
    tick(); exp_ret++;
    checks++; if (retired !== 4'd0) begin failures++; $display("FAIL retired_wrap got=%0d exp=0", retired); end
    clear_inputs();
  endtask

  task automatic test_reset_in_trap();
    clear_inputs();
    in_valid = 1; in_alu_op = ALU_OP_SUB; in_trap_of = 1; in_of = 1; in_pc = 32'h60;
    tick();
    checks++; if (exc_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_trap got=%0b exp=1", exc_valid); end
    clear_inputs(); reset = 1;
    tick();
    reset = 0; exp_ret = '0;
    checks++; if (exc_valid !== 1'b0 || exc_code !== 2'b00 || exc_pc !== 32'h0) begin failures++; $display("FAIL reset_trap_exc got=%0b/%0b/%0h exp=0/00/0", exc_valid, exc_code, exc_pc); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0 || retired !== 4'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin failures++; $display("FAIL reset_trap_regs got=%0h/%0h/%0d/%0b/%0h exp=0", hi, lo, retired, out_valid, out_pc); end
    in_valid = 1; in_alu_op = ALU_OP_XOR; in_result = 32'h77; in_pc = 32'h64;
    tick(); exp_ret++;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h77 || retired !== exp_ret) begin failures++; $display("FAIL run_after_reset got=%0b/%0h/%0d exp=1/77/%0d", out_valid, out_result, retired, exp_ret); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    exp_ret = '0;
    test_reset();
    test_hilo();
    test_trap();
    test_branch();
    test_stall();
    test_reserved();
    test_wrap();
    test_reset_in_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ex_mem_stage
`default_nettype wire
